// File: rtl/leaf_uplink_arbiter.sv
// Round-robin merge of per-leaf valid/ready channels into one registered stream.
// Each grant accepts at most MAX_BURST words; release costs one idle arbitration cycle.
module leaf_uplink_arbiter #(
    parameter int NUM_LEAVES = 2,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int SRC_W      = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*NUM_LEAVES-1:0] in_data,
    input  logic [NUM_LEAVES-1:0]            in_valid,
    output logic [NUM_LEAVES-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SRC_W-1:0]                 out_src,
    output logic                             busy
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                               state, state_nxt;
    logic [SRC_W-1:0]                     gnt, gnt_nxt, ptr, ptr_nxt, pick;
    logic [CNT_W-1:0]                     cnt, cnt_nxt;
    logic                                 can_load, xfer, rel, found;
    logic [NUM_LEAVES-1:0][DATA_WIDTH-1:0] in_words;

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_word
        assign in_words[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign can_load = !out_valid || out_ready;
    assign xfer     = (state == GRANT) && can_load && in_valid[gnt];
    // A stalled output holds the grant; only a loadable cycle can end it.
    assign rel      = (state == GRANT) && can_load &&
                      (!in_valid[gnt] || cnt == CNT_W'(MAX_BURST - 1));
    assign busy     = (state == GRANT);

    // First valid leaf scanning from ptr upward with wrap at NUM_LEAVES.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            idx = (int'(ptr) + k) % NUM_LEAVES;
            if (!found && in_valid[idx]) begin
                pick  = SRC_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state == GRANT && can_load)
            in_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (found) begin
                gnt_nxt   = pick;
                cnt_nxt   = '0;
                state_nxt = GRANT;
            end
            GRANT: begin
                if (xfer)
                    cnt_nxt = cnt + 1'b1;
                if (rel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ptr_nxt   = (gnt == SRC_W'(NUM_LEAVES - 1)) ? '0 : gnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= in_words[gnt];
            out_src   <= gnt;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Randomized bench for leaf_uplink_arbiter (3 leaves, burst 3) against a grant/burst-count model.
module tb_leaf_uplink_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int MB = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW*N-1:0] in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SW-1:0]   out_src;
    logic            busy;

    leaf_uplink_arbiter #(.NUM_LEAVES(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: which leaf holds the grant (if any), words taken so far, next start leaf,
    // and the single output buffer.
    bit          m_busy = 0;
    int          m_gnt = 0, m_ptr = 0, m_taken = 0, m_os = 0;
    bit          m_ov = 0;
    logic [DW-1:0] m_od = '0;
    int          seq [N];
    logic [N-1:0] exp_rdy;

    function automatic logic [DW-1:0] word_of(int leaf);
        return {8'(leaf), 8'(seq[leaf])};
    endfunction

    task automatic model_step();
        bit can, load;
        if (reset) begin
            m_busy = 0; m_gnt = 0; m_ptr = 0; m_taken = 0;
            m_ov = 0; m_od = '0; m_os = 0;
            return;
        end
        can  = !m_ov || out_ready;
        load = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!m_busy && in_valid[j]) begin
                    m_busy = 1; m_gnt = j; m_taken = 0;
                end
            end
        end else if (can) begin
            if (in_valid[m_gnt]) begin
                load = 1;
                m_od = word_of(m_gnt);
                m_os = m_gnt;
                seq[m_gnt]++;
                m_taken++;
            end
            if (!load || m_taken == MB) begin
                m_busy = 0;
                m_ptr  = (m_gnt + 1) % N;
            end
        end
        if (load) m_ov = 1;
        else if (m_ov && out_ready) m_ov = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            reset = (cyc < 2) || (cyc == 200);
            if (cyc < 40) begin
                in_valid  = '1;
                out_ready = 1'b1;
            end else if (cyc < 300) begin
                for (int i = 0; i < N; i++) in_valid[i] = ($urandom_range(0, 9) < 7);
                out_ready = (cyc >= 100 && cyc < 106) ? 1'b0 : ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = (cyc < 330) ? 3'b100 : 3'b101;
                out_ready = ($urandom_range(0, 4) != 0);
            end
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = word_of(i);
            #1;
            exp_rdy = '0;
            if (m_busy && (!m_ov || out_ready)) exp_rdy[m_gnt] = 1'b1;
            chk("in_ready",  32'(in_ready),  32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_data",  32'(out_data),  32'(m_od));
            chk("out_src",   32'(out_src),   32'(m_os));
            chk("busy",      32'(busy),      32'(m_busy));
            @(posedge clk);
            model_step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
